pll_rst_gen: RTL and testbench
==============================

// Module: pll_rst_gen
// PURPOSE
//   Downstream of the PLL: consumes its asynchronous `locked` flag in the sys_clk domain.
//   Produces a clean active-high reset and a ready flag for user logic once lock has been stable.
//   Asserts the reset again on any loss of lock, and records lock-loss events for debug.
// PARAMETERS
//   SYNC_STAGES    2     flops in the `locked` synchroniser; must be >= 2
//   STABLE_CYCLES  1000  consecutive cycles locked_s must stay high before HOLD; >= 1
//   HOLD_CYCLES    16    extra cycles rst_out is held after stability is confirmed; >= 1
//   CNT_W          8     width of loss_cnt
// PORTS
//   sys_clk   in   1      single clock; all state on rising edge
//   sys_rst   in   1      asynchronous, active-high reset
//   locked    in   1      PLL lock flag; asynchronous to sys_clk
//   clr_err   in   1      synchronous pulse; clears lock_err
//   rst_out   out  1      active-high reset to downstream logic; registered
//   ready     out  1      1 only in RUN; registered; always equal to ~rst_out
//   lock_err  out  1      sticky; set on every RUN->WAIT_LOCK transition
//   loss_cnt  out  CNT_W  saturating count of RUN->WAIT_LOCK transitions
// BEHAVIOUR
//   - sys_rst=1 (async, immediate) clears the following:
//     - sync chain=0, state=WAIT_LOCK, counter=0
//     - rst_out=1, ready=0, lock_err=0, loss_cnt=0
//   - Synchroniser: locked_s = locked delayed through SYNC_STAGES flops; locked is used nowhere else.
//   - One cycle counter, width $clog2(max(STABLE_CYCLES,HOLD_CYCLES))+1.
//     - It is zeroed on every state change.
//   - FSM (2-bit):
//     - WAIT_LOCK: locked_s=1 -> STABLE.
//     - STABLE: counts cycles with locked_s=1.
//       - locked_s=0 -> WAIT_LOCK. No error and no count, because RUN was never reached.
//       - counter==STABLE_CYCLES-1 with locked_s=1 -> HOLD.
//     - HOLD: locked_s=0 -> WAIT_LOCK (no error); counter==HOLD_CYCLES-1 -> RUN.
//     - RUN: locked_s=0 -> WAIT_LOCK, and on that same edge:
//       - lock_err<=1
//       - loss_cnt<=loss_cnt+1, saturating at all-ones
//   - Outputs are registered from the next state, so they change on the same edge as the state:
//     - rst_out=0 and ready=1 only while in RUN.
//   - Timing, with E0 = first rising edge that samples locked=1 (locked then steady):
//     - WAIT_LOCK->STABLE on edge E(SYNC_STAGES).
//     - ready rises on edge E(SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES).
//   - Loss timing: locked falls in RUN, first sampled low on edge F0.
//     - rst_out=1 and lock_err=1 on edge F(SYNC_STAGES).
//   - Glitches: any low on locked_s during STABLE or HOLD restarts the full sequence.
//     - Pulses on locked shorter than one cycle may be missed; this is acceptable.
//   - clr_err: lock_err<=0. A loss event on the same edge wins, so lock_err stays 1.
//     - clr_err does not affect loss_cnt; only sys_rst clears it.
//   - sys_rst asserted mid-sequence or in RUN: immediate return to reset values.
//     - On release, the sequence restarts from WAIT_LOCK.
// CONFIGURATION
//   - LOCK_LOSS_CNT_EN defined: the loss_cnt register and increment logic are built as above.
//   - LOCK_LOSS_CNT_EN undefined:
//     - loss_cnt is tied to all-zero; no counter flops are built.
//     - lock_err, rst_out and ready behave identically.
// TESTING  (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2, 20 ns sys_clk)
//   1. Release sys_rst, locked=0 for 50 cycles.
//      -> rst_out=1, ready=0, loss_cnt=0 throughout.
//   2. locked=1 sampled at E0, held high.
//      -> ready=1 and rst_out=0 first at E14, not at E13.
//   3. From RUN, drop locked at F0.
//      -> rst_out=1, ready=0, lock_err=1, loss_cnt=1 at F2.
//      -> Re-raise locked: ready returns 14 edges later.
//   4. During STABLE, drop locked for 3 cycles, then raise it.
//      -> lock_err=0, loss_cnt=0; ready rises 14 edges after the re-rise.
//   5. Four lock losses from RUN.
//      -> loss_cnt reads 1, 2, 3, 3 (saturates).
//      -> clr_err pulse -> lock_err=0, loss_cnt=3.
//      -> clr_err on the same edge as a loss -> lock_err=1.
//   6. Assert sys_rst mid-HOLD, and again in RUN.
//      -> Outputs go to reset values without a clock edge.
//      -> After release, full 14-edge sequence again.
//      -> Rerun 3 and 5 with LOCK_LOSS_CNT_EN undefined: loss_cnt=0 always.

Source files
------------

// File: rtl/pll_rst_gen.sv
// rtl/pll_rst_gen.sv - PLL lock synchroniser and reset sequencer; optional loss counter under LOCK_LOSS_CNT_EN
module pll_rst_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             locked,
    input  logic             clr_err,
    output logic             rst_out,
    output logic             ready,
    output logic             lock_err,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_STABLE    = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic                   lock_err_q, lock_err_d;
    logic                   locked_s;
    logic                   loss_evt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Shift the raw lock flag into the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked};
    end

    // Sequencer: any low on locked_s before RUN silently restarts; a low in RUN is a loss event
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        case (state_q)
            S_WAIT_LOCK: begin
                if (locked_s) state_d = S_STABLE;
            end
            S_STABLE: begin
                if (!locked_s)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_HOLD;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            S_HOLD: begin
                if (!locked_s)              state_d = S_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = S_RUN;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_WAIT_LOCK;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = S_WAIT_LOCK;
        endcase
        // The shared counter always starts from zero in the state just entered
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs follow the next state so they move on the same edge as the FSM
    always_comb begin
        rst_out_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        // A loss on the same edge as clr_err must not be lost
        if (loss_evt)     lock_err_d = 1'b1;
        else if (clr_err) lock_err_d = 1'b0;
        else              lock_err_d = lock_err_q;
    end

    // State registers with asynchronous reset to the held-in-reset condition
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q     <= '0;
            state_q    <= S_WAIT_LOCK;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            ready_q    <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign ready    = ready_q;
    assign lock_err = lock_err_q;

`ifdef LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q, loss_d;

    // Saturating count of RUN exits; only sys_rst clears it
    always_comb begin
        loss_d = loss_q;
        if (loss_evt && (loss_q != {CNT_W{1'b1}})) loss_d = loss_q + CNT_W'(1);
    end

    // Loss counter register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) loss_q <= '0;
        else         loss_q <= loss_d;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_gen.sv
// tb/tb_pll_rst_gen.sv - directed scoreboard bench for pll_rst_gen
module tb_pll_rst_gen;

    localparam int SEQ = 2 + 8 + 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       locked;
    logic       clr_err;
    logic       rst_out;
    logic       ready;
    logic       lock_err;
    logic [1:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    logic       le_m;
    int         lc_m;

    typedef struct packed {
        logic       r;
        logic       rd;
        logic       le;
        logic [1:0] lc;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    pll_rst_gen #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (4),
        .CNT_W        (2)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .locked  (locked),
        .clr_err (clr_err),
        .rst_out (rst_out),
        .ready   (ready),
        .lock_err(lock_err),
        .loss_cnt(loss_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] exp_lc(input int raw);
`ifdef LOCK_LOSS_CNT_EN
        return (raw > 3) ? 2'd3 : raw[1:0];
`else
        return 2'd0 + 2'(raw * 0);
`endif
    endfunction

    task automatic chk(input string n, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", n, obs, exp);
        end
    endtask

    task automatic push(input string n, input logic r, input logic rd);
        exp_t e;
        e.r  = r;
        e.rd = rd;
        e.le = le_m;
        e.lc = exp_lc(lc_m);
        exp_q.push_back(e);
        nm_q.push_back(n);
    endtask

    task automatic pop_compare();
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk({n, ".rst_out"},  {1'b0, rst_out},  {1'b0, e.r});
        chk({n, ".ready"},    {1'b0, ready},    {1'b0, e.rd});
        chk({n, ".lock_err"}, {1'b0, lock_err}, {1'b0, e.le});
        chk({n, ".loss_cnt"}, loss_cnt,         e.lc);
    endtask

    // one clock edge, then compare against what was expected for that edge
    task automatic cyc(input string n, input logic r, input logic rd);
        push(n, r, rd);
        @(posedge sys_clk);
        #1;
        pop_compare();
    endtask

    // locked is already high and the chain is cold: 14 edges to ready
    task automatic ramp(input string n);
        for (int i = 0; i < SEQ; i++) cyc({n, ".ramp"}, 1'b1, 1'b0);
        cyc({n, ".ready"}, 1'b0, 1'b1);
    endtask

    // drop locked while in RUN; optional clr_err on the loss edge
    task automatic lose(input string n, input logic clr);
        locked = 1'b0;
        cyc({n, ".f0"}, 1'b0, 1'b1);
        cyc({n, ".f1"}, 1'b0, 1'b1);
        clr_err = clr;
        le_m = 1'b1;
        lc_m = lc_m + 1;
        cyc({n, ".f2"}, 1'b1, 1'b0);
        clr_err = 1'b0;
    endtask

    // assert sys_rst between edges and check outputs before any edge
    task automatic async_reset(input string n);
        #4;
        sys_rst = 1'b1;
        #1;
        le_m = 1'b0;
        lc_m = 0;
        push(n, 1'b1, 1'b0);
        pop_compare();
        #5;
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        locked  = 1'b0;
        clr_err = 1'b0;
        le_m    = 1'b0;
        lc_m    = 0;

        #5;
        push("reset", 1'b1, 1'b0);
        pop_compare();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // 1: no lock
        for (int i = 0; i < 50; i++) cyc("nolock", 1'b1, 1'b0);

        // 2: lock and reach RUN exactly at E14
        locked = 1'b1;
        ramp("lock");

        // 3: lose lock, recover
        lose("loss1", 1'b0);
        locked = 1'b1;
        ramp("relock");

        // 4: glitch during STABLE from a clean reset
        async_reset("rst_run0");
        for (int i = 0; i < 5; i++) cyc("pre_glitch", 1'b1, 1'b0);
        locked = 1'b0;
        for (int i = 0; i < 3; i++) cyc("glitch", 1'b1, 1'b0);
        locked = 1'b1;
        ramp("after_glitch");

        // 5: four losses, saturation, clr_err
        for (int k = 0; k < 4; k++) begin
            lose("multi", 1'b0);
            cyc("multi.idle", 1'b1, 1'b0);
            if (k < 3) begin
                locked = 1'b1;
                ramp("multi");
            end
        end
        clr_err = 1'b1;
        le_m = 1'b0;
        cyc("clr", 1'b1, 1'b0);
        clr_err = 1'b0;
        cyc("clr.after", 1'b1, 1'b0);
        locked = 1'b1;
        ramp("pre_clr_loss");
        lose("clr_loss", 1'b1);
        cyc("clr_loss.hold", 1'b1, 1'b0);

        // 6: reset mid-HOLD and in RUN
        locked = 1'b1;
        for (int i = 0; i < 12; i++) cyc("to_hold", 1'b1, 1'b0);
        async_reset("rst_hold");
        ramp("after_rst_hold");
        cyc("run", 1'b0, 1'b1);
        async_reset("rst_run");
        ramp("after_rst_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
